// File: rtl/btn_pkg.sv
// Shared types and defaults for the button debounce block.
package btn_pkg;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } btn_db_state_t;

   localparam int N_BTN_DEF           = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, edge pulses.
// Sticky press flag present only when BTN_DEBOUNCE_STICKY_EN is defined.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_in,
   input  logic press_clr,
   output logic btn_stable,
   output logic btn_rise,
   output logic btn_fall,
   output logic press_flag
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_ff1;
   logic          r_ff2;
   btn_db_state_t r_state;
   logic [CW-1:0] r_cnt;
   logic          r_stable;
   logic          r_rise;
   logic          r_fall;

   btn_db_state_t w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_accept;
   logic          w_diff;
   logic          w_stable_nxt;
   logic          w_rise_nxt;
   logic          w_fall_nxt;

   assign w_diff = r_ff2 ^ r_stable;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ff1    <= 1'b0;
         r_ff2    <= 1'b0;
         r_state  <= STABLE;
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_ff1    <= btn_in;
         r_ff2    <= r_ff1;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_stable <= w_stable_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      unique case (r_state)
         STABLE: begin
            w_cnt_nxt = '0;
            if (w_diff) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  w_accept = 1'b1;
               end else begin
                  w_state_nxt = PENDING;
                  w_cnt_nxt   = CNT_ONE;
               end
            end
         end
         PENDING: begin
            if (!w_diff) begin
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_accept    = 1'b1;
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
      endcase
   end

   always_comb begin
      w_stable_nxt = w_accept ? r_ff2 : r_stable;
      w_rise_nxt   = w_accept & r_ff2;
      w_fall_nxt   = w_accept & ~r_ff2;
   end

   assign btn_stable = r_stable;
   assign btn_rise   = r_rise;
   assign btn_fall   = r_fall;

`ifdef BTN_DEBOUNCE_STICKY_EN
   logic r_flag;

   // Flag follows the registered rise, so a clear seen alongside it loses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_flag <= 1'b0;
      end else if (r_rise) begin
         r_flag <= 1'b1;
      end else if (press_clr) begin
         r_flag <= 1'b0;
      end
   end

   assign press_flag = r_flag;
`else
   logic w_clr_unused;

   assign w_clr_unused = press_clr;
   assign press_flag   = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: N_BTN independent debounce channels.
// Optional sticky press flags via BTN_DEBOUNCE_STICKY_EN.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int N_BTN           = N_BTN_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   input  logic [N_BTN-1:0] press_clr,
   output logic [N_BTN-1:0] btn_stable,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic [N_BTN-1:0] press_flags
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clock     (clock),
         .reset     (reset),
         .btn_in    (btn_in[i]),
         .press_clr (press_clr[i]),
         .btn_stable(btn_stable[i]),
         .btn_rise  (btn_rise[i]),
         .btn_fall  (btn_fall[i]),
         .press_flag(press_flags[i])
      );
   end

endmodule
